ntt_stage_sequencer: RTL and testbench

- Parametrised control block that drives an in-place radix-2 NTT/INTT over a banked coefficient memory. It generalises the fixed 8-lane, 3-bit `point` engine to any transform size up to 2^MAX_LOG_N.
- Runs one butterfly per cycle and steps through all log_n stages, inserting pipeline-drain gaps so the next stage never reads data still being written.
- Emits read/write addresses, twiddle index, stage number and last-stage flag to the butterfly datapath and twiddle ROM.
- Start/busy/done handshake; external stall.

---
 rtl/ntt_seq_pkg.sv | 23 ++
 rtl/ntt_addr_gen.sv | 37 +++
 rtl/ntt_stage_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_seq_pkg.sv
// Shared types and constants for the NTT stage sequencer.
//   state_e       : sequencer FSM states
//   DefMaxLogN    : default largest supported log2(N)
//   DefPipeLat    : default butterfly read-to-writeback latency
//   half_size()   : N/2 for a given log2(N) (0 for log_n == 0)
package ntt_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StScale,
    StDone
  } state_e;

  localparam int unsigned DefMaxLogN = 10;
  localparam int unsigned DefPipeLat = 4;

  function automatic int unsigned half_size(input int unsigned log_n);
    return (log_n == 0) ? 32'd0 : (32'd1 << (log_n - 32'd1));
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address / twiddle generator for one radix-2 stage.
// Ports:
//   k       in  butterfly counter within the stage (0..N/2-1)
//   s       in  stage number
//   log_n   in  log2 of the transform size
//   addr_a  out top index    = ((k>>s)<<(s+1)) | (k & (half-1))
//   addr_b  out bottom index = addr_a + half
//   tw_idx  out twiddle index = (k & (half-1)) << (log_n-1-s)
module ntt_addr_gen #(
  parameter int unsigned MAX_LOG_N = 10,
  parameter int unsigned LOGN_W    = $clog2(MAX_LOG_N + 1)
) (
  input  logic [MAX_LOG_N-1:0] k,
  input  logic [LOGN_W-1:0]    s,
  input  logic [LOGN_W-1:0]    log_n,
  output logic [MAX_LOG_N-1:0] addr_a,
  output logic [MAX_LOG_N-1:0] addr_b,
  output logic [MAX_LOG_N-2:0] tw_idx
);

  logic [MAX_LOG_N-1:0] half;
  logic [MAX_LOG_N-1:0] mask;
  logic [MAX_LOG_N-1:0] group_base;
  logic [LOGN_W-1:0]    tw_shift;

  always_comb begin
    half       = MAX_LOG_N'(1) << s;
    mask       = half - MAX_LOG_N'(1);
    group_base = (k >> s) << (s + LOGN_W'(1));
    addr_a     = group_base | (k & mask);
    addr_b     = addr_a + half;
    tw_shift   = log_n - s - LOGN_W'(1);
    // mask < 2^(MAX_LOG_N-1), so the dropped top bit of k & mask is always 0.
    tw_idx     = (k[MAX_LOG_N-2:0] & mask[MAX_LOG_N-2:0]) << tw_shift;
  end

endmodule

// File: rtl/ntt_stage_sequencer.sv
// In-place radix-2 NTT/INTT stage sequencer: one butterfly per cycle over all
// log_n stages, with a PIPE_LAT drain gap after every stage so a stage never
// reads data still in the butterfly pipeline.
// Optional feature macro: NTT_SEQ_INTT_SCALE_EN adds an N^-1 scaling pass
// (SCALE state) after the final drain of an inverse transform.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start/log_n/inverse  request; sampled only in idle
//   stall             freezes the sequencer
//   busy, done        handshake (done is a one-cycle pulse)
//   cfg_err           one-cycle pulse for a start with illegal log_n
//   bf_valid, addr_a, addr_b, tw_idx, tw_inv, stage, last_stage  datapath control
//   scale_valid       scaling-pass element valid (addr_a = element index)
module ntt_stage_sequencer
  import ntt_seq_pkg::*;
#(
  parameter int unsigned MAX_LOG_N = DefMaxLogN,
  parameter int unsigned PIPE_LAT  = DefPipeLat,
  parameter int unsigned LOGN_W    = $clog2(MAX_LOG_N + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LOGN_W-1:0]    log_n,
  input  logic                 inverse,
  input  logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 bf_valid,
  output logic [MAX_LOG_N-1:0] addr_a,
  output logic [MAX_LOG_N-1:0] addr_b,
  output logic [MAX_LOG_N-2:0] tw_idx,
  output logic                 tw_inv,
  output logic [LOGN_W-1:0]    stage,
  output logic                 last_stage,
  output logic                 scale_valid
);

  localparam int unsigned DrainW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e               state_q;
  logic [MAX_LOG_N-1:0] k_q;
  logic [LOGN_W-1:0]    s_q;
  logic [LOGN_W-1:0]    log_n_q;
  logic [DrainW-1:0]    drain_q;
  logic                 inv_q;
  logic                 cfg_err_q;

  logic [MAX_LOG_N-1:0] k_last;
  logic                 log_n_ok;
  logic                 final_stage;
  logic                 drain_end;
  logic                 scale_phase;

  logic [MAX_LOG_N-1:0] gen_a;
  logic [MAX_LOG_N-1:0] gen_b;
  logic [MAX_LOG_N-2:0] gen_tw;

`ifdef NTT_SEQ_INTT_SCALE_EN
  logic                 scaled_q;  // set once the scaling pass has been issued
  logic [MAX_LOG_N-1:0] n_last;
  assign n_last = MAX_LOG_N'((half_size(32'(log_n_q)) << 1) - 32'd1);
`endif

  assign k_last      = MAX_LOG_N'(half_size(32'(log_n_q)) - 32'd1);
  assign log_n_ok    = (log_n != '0) && (log_n <= LOGN_W'(MAX_LOG_N));
  assign final_stage = (s_q == log_n_q - LOGN_W'(1));
  assign drain_end   = (drain_q == DrainW'(PIPE_LAT - 1));

  ntt_addr_gen #(
    .MAX_LOG_N (MAX_LOG_N),
    .LOGN_W    (LOGN_W)
  ) u_addr_gen (
    .k      (k_q),
    .s      (s_q),
    .log_n  (log_n_q),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      s_q       <= '0;
      log_n_q   <= '0;
      drain_q   <= '0;
      inv_q     <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef NTT_SEQ_INTT_SCALE_EN
      scaled_q  <= 1'b0;
`endif
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (log_n_ok) begin
              log_n_q <= log_n;
              inv_q   <= inverse;
              s_q     <= '0;
              k_q     <= '0;
              state_q <= StRun;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (!stall) begin
            // k stays on the last butterfly so addresses hold through the drain.
            if (k_q == k_last) begin
              drain_q <= '0;
              state_q <= StDrain;
            end else begin
              k_q <= k_q + MAX_LOG_N'(1);
            end
          end
        end
        StDrain: begin
          if (!stall) begin
            if (!drain_end) begin
              drain_q <= drain_q + DrainW'(1);
`ifdef NTT_SEQ_INTT_SCALE_EN
            end else if (scaled_q) begin
              state_q <= StDone;
`endif
            end else if (!final_stage) begin
              s_q     <= s_q + LOGN_W'(1);
              k_q     <= '0;
              state_q <= StRun;
`ifdef NTT_SEQ_INTT_SCALE_EN
            end else if (inv_q) begin
              k_q     <= '0;
              state_q <= StScale;
`endif
            end else begin
              state_q <= StDone;
            end
          end
        end
`ifdef NTT_SEQ_INTT_SCALE_EN
        StScale: begin
          if (!stall) begin
            if (k_q == n_last) begin
              scaled_q <= 1'b1;
              drain_q  <= '0;
              state_q  <= StDrain;
            end else begin
              k_q <= k_q + MAX_LOG_N'(1);
            end
          end
        end
`endif
        StDone: begin
`ifdef NTT_SEQ_INTT_SCALE_EN
          scaled_q <= 1'b0;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef NTT_SEQ_INTT_SCALE_EN
  assign scale_phase = (state_q == StScale) || ((state_q == StDrain) && scaled_q);
`else
  assign scale_phase = 1'b0;
`endif

  always_comb begin
    busy        = (state_q == StRun) || (state_q == StDrain) || (state_q == StScale);
    done        = (state_q == StDone);
    cfg_err     = cfg_err_q;
    tw_inv      = inv_q;
    bf_valid    = (state_q == StRun) && !stall;
`ifdef NTT_SEQ_INTT_SCALE_EN
    scale_valid = (state_q == StScale) && !stall;
`else
    scale_valid = 1'b0;
`endif
    addr_a      = '0;
    addr_b      = '0;
    tw_idx      = '0;
    stage       = '0;
    last_stage  = 1'b0;
    if (busy) begin
      stage      = s_q;
      last_stage = final_stage;
      if (scale_phase) begin
        addr_a = k_q;
      end else begin
        addr_a = gen_a;
        addr_b = gen_b;
        tw_idx = gen_tw;
      end
    end
  end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Self-checking bench for ntt_stage_sequencer: a schedule model (nested loops
// over stages/groups/butterflies plus drain gaps) is consumed by one compare
// process, one entry per unstalled busy cycle.
module tb_ntt_stage_sequencer;

  localparam int unsigned MaxLogN = 10;
  localparam int unsigned PipeLat = 4;
  localparam int unsigned LognW   = 4;
  localparam int          Budget  = 20000;
  localparam int          KGap    = 0;
  localparam int          KBf     = 1;
  localparam int          KScale  = 2;
`ifdef NTT_SEQ_INTT_SCALE_EN
  localparam bit ScaleEn = 1'b1;
`else
  localparam bit ScaleEn = 1'b0;
`endif

  typedef struct {
    int kind;
    int a;
    int b;
    int tw;
    int stg;
    bit last;
  } step_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [LognW-1:0]   log_n = '0;
  logic               inverse = 1'b0;
  logic               stall = 1'b0;
  logic               busy, done, cfg_err, bf_valid, tw_inv, last_stage, scale_valid;
  logic [MaxLogN-1:0] addr_a, addr_b;
  logic [MaxLogN-2:0] tw_idx;
  logic [LognW-1:0]   stage;

  always #5 clk = ~clk;

  ntt_stage_sequencer #(
    .MAX_LOG_N (MaxLogN),
    .PIPE_LAT  (PipeLat),
    .LOGN_W    (LognW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .log_n       (log_n),
    .inverse     (inverse),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .bf_valid    (bf_valid),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .tw_idx      (tw_idx),
    .tw_inv      (tw_inv),
    .stage       (stage),
    .last_stage  (last_stage),
    .scale_valid (scale_valid)
  );

  // Written by the driver only.
  step_t exp_q[$];
  int    run_id = 0;
  bit    run_on = 1'b0;
  bit    chk_en = 1'b0;
  bit    exp_inv = 1'b0;
  bit    exp_cfg_err = 1'b0;
  int    start_cyc = 0;
  int    exp_lat = 0;
  // Written by the compare process only.
  int    n_checks = 0;
  int    n_errors = 0;
  int    pos = 0;
  int    cur_id = 0;
  int    fin_id = 0;
  int    act_cycles = 0;
  // Written by the cycle counter only.
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected schedule: per stage, butterflies group by group, then PipeLat gaps.
  task automatic build_model(input int ln, input bit inv);
    step_t st;
    int n;
    n = 1 << ln;
    exp_q.delete();
    for (int s = 0; s < ln; s++) begin
      int half;
      int groups;
      half   = 1 << s;
      groups = n / (2 * half);
      for (int g = 0; g < groups; g++) begin
        for (int j = 0; j < half; j++) begin
          st.kind = KBf;
          st.a    = g * 2 * half + j;
          st.b    = g * 2 * half + j + half;
          st.tw   = j * groups;
          st.stg  = s;
          st.last = (s == ln - 1);
          exp_q.push_back(st);
        end
      end
      for (int d = 0; d < int'(PipeLat); d++) begin
        st.kind = KGap;
        exp_q.push_back(st);
      end
    end
    if (inv && ScaleEn) begin
      for (int i = 0; i < n; i++) begin
        st.kind = KScale;
        st.a    = i;
        st.b    = 0;
        exp_q.push_back(st);
      end
      for (int d = 0; d < int'(PipeLat); d++) begin
        st.kind = KGap;
        exp_q.push_back(st);
      end
    end
  endtask

  always @(negedge clk) begin : compare
    step_t st;
    if (chk_en) begin
      if (cur_id != run_id) begin
        cur_id     = run_id;
        pos        = 0;
        act_cycles = 0;
        if (run_id == 1) begin
          // Hand-derived log_n=3 schedule entries pin the model itself.
          chk("pin_size", exp_q.size(), 24);
          chk("pin_s0k3_a", exp_q[3].a, 6);
          chk("pin_gap_kind", exp_q[4].kind, KGap);
          chk("pin_s1k1_b", exp_q[9].b, 3);
          chk("pin_s1k1_tw", exp_q[9].tw, 2);
          chk("pin_s2k3_a", exp_q[19].a, 3);
          chk("pin_s2k3_b", exp_q[19].b, 7);
          chk("pin_s2k3_tw", exp_q[19].tw, 3);
          chk("pin_s2k3_last", int'(exp_q[19].last), 1);
        end
      end
      if (run_on && fin_id != run_id) begin
        act_cycles++;
        if (act_cycles == Budget) chk("timeout", 1, 0);
        chk("tw_inv", int'(tw_inv), int'(exp_inv));
        if (pos < exp_q.size()) begin
          chk("busy", int'(busy), 1);
          chk("done_early", int'(done), 0);
          if (stall) begin
            chk("stall_bf_valid", int'(bf_valid), 0);
            chk("stall_scale_valid", int'(scale_valid), 0);
            if (exp_q[pos].kind == KBf) begin
              chk("hold_addr_a", int'(addr_a), exp_q[pos].a);
              chk("hold_addr_b", int'(addr_b), exp_q[pos].b);
            end
          end else begin
            st = exp_q[pos];
            pos++;
            chk("bf_valid", int'(bf_valid), int'(st.kind == KBf));
            chk("scale_valid", int'(scale_valid), int'(st.kind == KScale));
            if (st.kind == KBf) begin
              chk("addr_a", int'(addr_a), st.a);
              chk("addr_b", int'(addr_b), st.b);
              chk("tw_idx", int'(tw_idx), st.tw);
              chk("stage", int'(stage), st.stg);
              chk("last_stage", int'(last_stage), int'(st.last));
            end else if (st.kind == KScale) begin
              chk("scale_addr_a", int'(addr_a), st.a);
              chk("scale_addr_b", int'(addr_b), 0);
            end
          end
        end else begin
          chk("done", int'(done), 1);
          chk("done_busy", int'(busy), 0);
          chk("done_bf_valid", int'(bf_valid), 0);
          chk("latency", cyc - start_cyc, exp_lat);
          fin_id = run_id;
        end
      end else begin
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_bf_valid", int'(bf_valid), 0);
        chk("idle_scale_valid", int'(scale_valid), 0);
        chk("cfg_err", int'(cfg_err), int'(exp_cfg_err));
        chk("idle_tw_inv", int'(tw_inv), int'(exp_inv));
        chk("idle_addr_a", int'(addr_a), 0);
        chk("idle_addr_b", int'(addr_b), 0);
        chk("idle_tw_idx", int'(tw_idx), 0);
        chk("idle_stage", int'(stage), 0);
        chk("idle_last_stage", int'(last_stage), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      start = 1'b0;
      stall = 1'b0;
    end
  endtask

  task automatic launch(input int ln, input bit inv, input int lat);
    tick();
    log_n     = LognW'(ln);
    inverse   = inv;
    start     = 1'b1;
    stall     = 1'b0;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    build_model(ln, inv);
    exp_inv = inv;
    exp_lat = lat;
    run_id++;
    run_on  = 1'b1;
  endtask

  // Runs until the done cycle has been checked (or aborts on reset_at).
  task automatic run(input int stall_from, input int stall_len, input int busy_start_at,
                     input bit done_start, input int reset_at);
    int  rel;
    int  guard;
    bit  rst_pending;
    guard       = 0;
    rst_pending = 1'b0;
    forever begin
      tick();
      if (rst_pending) begin
        rst_n   = 1'b1;
        run_on  = 1'b0;
        exp_inv = 1'b0;
        exp_q.delete();
        break;
      end
      if (!(run_on && fin_id != run_id)) break;
      rel   = cyc - start_cyc;
      stall = (rel >= stall_from) && (rel < stall_from + stall_len);
      start = 1'b0;
      if (rel == busy_start_at || (done_start && pos == exp_q.size())) begin
        start   = 1'b1;
        log_n   = LognW'(2);
        inverse = ~exp_inv;
      end
      if (rel == reset_at) begin
        rst_n       = 1'b0;
        rst_pending = 1'b1;
      end
      guard++;
      if (guard > Budget + 50) begin
        run_on = 1'b0;
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(3);

    // Forward log_n=3 reference run.
    launch(3, 1'b0, 25);
    run(-1, 0, -1, 1'b0, -1);
    idle(2);

    // Illegal sizes: 0 and MAX_LOG_N+1.
    tick(); log_n = LognW'(0); start = 1'b1;
    tick(); start = 1'b0; exp_cfg_err = 1'b1;
    tick(); exp_cfg_err = 1'b0; log_n = LognW'(MaxLogN + 1); start = 1'b1;
    tick(); start = 1'b0; exp_cfg_err = 1'b1;
    tick(); exp_cfg_err = 1'b0;
    idle(2);

    // Stall cycles 10-12 on stage-1 butterfly (1,3).
    launch(3, 1'b0, 28);
    run(10, 3, -1, 1'b0, -1);
    idle(2);

    // Reset mid-run, then a fresh log_n=2 run.
    launch(5, 1'b0, 0);
    run(-1, 0, -1, 1'b0, 10);
    idle(2);
    launch(2, 1'b0, 13);
    run(-1, 0, -1, 1'b0, -1);
    idle(2);

    // Inverse log_n=2 (scaling pass only with the feature macro).
    launch(2, 1'b1, ScaleEn ? 21 : 13);
    run(-1, 0, -1, 1'b0, -1);
    idle(2);

    // Starts while busy and in the done cycle are both ignored.
    launch(3, 1'b1, ScaleEn ? 37 : 25);
    run(-1, 0, 6, 1'b1, -1);
    idle(3);

    // Size boundaries.
    launch(1, 1'b0, 6);
    run(-1, 0, -1, 1'b0, -1);
    idle(2);
    launch(int'(MaxLogN), 1'b0, 1 + int'(MaxLogN) * (512 + int'(PipeLat)));
    run(-1, 0, -1, 1'b0, -1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
